// File: rtl/com_send_arb.sv
// com_send_arb: round-robin arbiter that shares the single com transmit port among NUM_REQ sources.
// Optional SEND-state watchdog is built when COM_ARB_TIMEOUT_EN is defined.
module com_send_arb #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2,
  parameter int TIMEOUT = 1024
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     fs_req,
  output logic [NUM_REQ-1:0]     fd_req,
  input  logic [4*NUM_REQ-1:0]   req_btype,
  output logic                   fs_com_send,
  input  logic                   fd_com_send,
  output logic [3:0]             send_btype,
  output logic [IDX_W-1:0]       send_idx,
  output logic                   err_timeout,
  input  logic                   err_clr
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2,
    RSVD = 2'd3
  } state_t;

  state_t               state;
  logic [IDX_W-1:0]     ptr;
  logic                 sel_valid;
  logic [IDX_W-1:0]     sel_idx;
  logic [3:0]           sel_btype;
  int                   rot_dist;
  int                   best_dist;
  logic [NUM_REQ-1:0]   grant_mask;
  logic                 req_held;
  logic                 send_timeout;

  // Winner is the requester closest to ptr going upward with wrap; only constant
  // indices into fs_req/req_btype are used, the rotation is pure arithmetic.
  always_comb begin
    // NOTE: every variable driven here gets a default first, so no latch is inferred.
    sel_valid = 1'b0;
    sel_idx   = '0;
    sel_btype = '0;
    best_dist = NUM_REQ;
    rot_dist  = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      rot_dist = (i >= int'(ptr)) ? (i - int'(ptr)) : (i + NUM_REQ - int'(ptr));
      if (fs_req[i] && (rot_dist < best_dist)) begin
        best_dist = rot_dist;
        sel_valid = 1'b1;
        sel_idx   = IDX_W'(i);
        sel_btype = req_btype[4*i +: 4];
      end
    end
  end

  assign grant_mask  = NUM_REQ'(1) << send_idx;
  assign req_held    = |(fs_req & grant_mask);
  assign fs_com_send = (state == SEND);
  assign fd_req      = (state == DONE) ? grant_mask : '0;

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register updates on the same edge.
    if (rst) begin
      state      <= IDLE;
      ptr        <= '0;
      send_idx   <= '0;
      send_btype <= 4'h0;
    end else begin
      case (state)
        IDLE: begin
          if (sel_valid) begin
            send_idx   <= sel_idx;
            send_btype <= sel_btype;
            state      <= SEND;
          end
        end
        SEND: begin
          if (fd_com_send || send_timeout) begin
            state <= DONE;
          end
        end
        DONE: begin
          // Released source moves the search start just past itself for fairness.
          if (!req_held) begin
            state <= IDLE;
            ptr   <= (int'(send_idx) == NUM_REQ - 1) ? '0 : send_idx + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef COM_ARB_TIMEOUT_EN
  logic [15:0] wd_cnt;

  // fd_com_send arriving on the limit cycle completes the transfer normally.
  assign send_timeout = (state == SEND) && !fd_com_send && (wd_cnt == 16'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_cnt      <= '0;
      err_timeout <= 1'b0;
    end else begin
      if ((state == IDLE) && sel_valid) begin
        wd_cnt <= '0;
      end else if (state == SEND) begin
        wd_cnt <= wd_cnt + 16'd1;
      end
      if (send_timeout) begin
        err_timeout <= 1'b1;
      end else if (err_clr) begin
        err_timeout <= 1'b0;
      end
    end
  end
`else
  logic unused_ok;

  assign send_timeout = 1'b0;
  assign err_timeout  = 1'b0;
  assign unused_ok    = &{1'b0, err_clr, 16'(TIMEOUT)};
`endif

endmodule

// File: tb/tb_com_send_arb.sv
// Self-checking bench for com_send_arb: directed scenarios plus randomized traffic
// checked against a round-robin reference model (grant order, type capture, fairness).
module tb_com_send_arb;
  localparam int NUM_REQ = 4;
  localparam int IDX_W   = 2;
  localparam int TIMEOUT = 16;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NUM_REQ-1:0]   fs_req;
  logic [NUM_REQ-1:0]   fd_req;
  logic [4*NUM_REQ-1:0] req_btype;
  logic                 fs_com_send;
  logic                 fd_com_send;
  logic [3:0]           send_btype;
  logic [IDX_W-1:0]     send_idx;
  logic                 err_timeout;
  logic                 err_clr;

  int checks = 0;
  int errors = 0;
  int m_ptr;

  always #5 clk = ~clk;

  com_send_arb #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W), .TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .rst         (rst),
    .fs_req      (fs_req),
    .fd_req      (fd_req),
    .req_btype   (req_btype),
    .fs_com_send (fs_com_send),
    .fd_com_send (fd_com_send),
    .send_btype  (send_btype),
    .send_idx    (send_idx),
    .err_timeout (err_timeout),
    .err_clr     (err_clr)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; fs_req = '0; fd_com_send = 1'b0; err_clr = 1'b0; req_btype = '0;
    tick(); tick();
    rst = 1'b0;
    m_ptr = 0;
    tick();
  endtask

  // Plays the com sender for one transfer and the source's release; records what it saw.
  task automatic run_xfer(input int fd_delay, output int idx, output logic [3:0] bt,
                          output logic [NUM_REQ-1:0] fd_seen, output logic fsc_seen, output bit ok);
    ok = 1'b0; idx = -1; bt = '0; fd_seen = '0; fsc_seen = 1'b1;
    for (int n = 0; n < 32; n++) begin
      if (fs_com_send === 1'b1) begin ok = 1'b1; break; end
      tick();
    end
    if (!ok) return;
    idx = int'(send_idx);
    bt  = send_btype;
    repeat (fd_delay) tick();
    fd_com_send = 1'b1;
    tick();
    fd_com_send = 1'b0;
    fd_seen  = fd_req;
    fsc_seen = fs_com_send;
    fs_req[idx] = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (fs_com_send !== 1'b0) begin errors++; $display("FAIL reset_fs_com_send got %b want 0", fs_com_send); end
    checks++; if (fd_req !== 4'b0000) begin errors++; $display("FAIL reset_fd_req got %b want 0000", fd_req); end
    checks++; if (send_idx !== 2'd0) begin errors++; $display("FAIL reset_send_idx got %0d want 0", send_idx); end
    checks++; if (send_btype !== 4'h0) begin errors++; $display("FAIL reset_send_btype got %h want 0", send_btype); end
    checks++; if (err_timeout !== 1'b0) begin errors++; $display("FAIL reset_err_timeout got %b want 0", err_timeout); end
  endtask

  task automatic test_single();
    do_reset();
    req_btype = {4'h3, 4'hD, 4'h7, 4'h1};
    fs_req = 4'b0100;
    tick();
    checks++; if (fs_com_send !== 1'b1) begin errors++; $display("FAIL single_grant_latency got %b want 1", fs_com_send); end
    checks++; if (send_idx !== 2'd2) begin errors++; $display("FAIL single_idx got %0d want 2", send_idx); end
    checks++; if (send_btype !== 4'hD) begin errors++; $display("FAIL single_btype got %h want d", send_btype); end
    tick(); tick();
    fd_com_send = 1'b1;
    tick();
    fd_com_send = 1'b0;
    checks++; if (fd_req !== 4'b0100 || fs_com_send !== 1'b0) begin errors++; $display("FAIL single_done got fd_req=%b fs=%b want 0100/0", fd_req, fs_com_send); end
    tick();
    checks++; if (fd_req !== 4'b0100) begin errors++; $display("FAIL single_done_hold got %b want 0100", fd_req); end
    fs_req = 4'b0000;
    tick();
    checks++; if (fd_req !== 4'b0000 || fs_com_send !== 1'b0) begin errors++; $display("FAIL single_idle got fd_req=%b fs=%b want 0000/0", fd_req, fs_com_send); end
    checks++; if (send_idx !== 2'd2 || send_btype !== 4'hD) begin errors++; $display("FAIL single_hold got idx=%0d bt=%h want 2/d", send_idx, send_btype); end
    tick();
    checks++; if (fs_com_send !== 1'b0) begin errors++; $display("FAIL single_no_regrant got %b want 0", fs_com_send); end
  endtask

  task automatic test_contention();
    int exp_order[5] = '{0, 1, 2, 3, 0};
    int idx; logic [3:0] bt; logic [NUM_REQ-1:0] fd_seen; logic fsc; bit ok;
    do_reset();
    req_btype = {4'h8, 4'h7, 4'h6, 4'h5};
    fs_req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      run_xfer(k % 2, idx, bt, fd_seen, fsc, ok);
      checks++; if (!ok || idx != exp_order[k]) begin errors++; $display("FAIL contention_order[%0d] got %0d want %0d", k, idx, exp_order[k]); end
      checks++; if (bt !== 4'(exp_order[k] + 5)) begin errors++; $display("FAIL contention_btype[%0d] got %h want %h", k, bt, 4'(exp_order[k] + 5)); end
      checks++; if (fd_seen !== 4'(1 << exp_order[k]) || fsc !== 1'b0) begin errors++; $display("FAIL contention_fd[%0d] got %b fs=%b want %b", k, fd_seen, fsc, 4'(1 << exp_order[k])); end
      if (ok) fs_req[idx] = 1'b1;
    end
    fs_req = '0;
    repeat (4) tick();
  endtask

  task automatic test_wrap();
    int idx; logic [3:0] bt; logic [NUM_REQ-1:0] fd_seen; logic fsc; bit ok;
    do_reset();
    req_btype = {4'hA, 4'hB, 4'hC, 4'hE};
    fs_req = 4'b1000;
    run_xfer(0, idx, bt, fd_seen, fsc, ok);
    checks++; if (!ok || idx != 3) begin errors++; $display("FAIL wrap_first got %0d want 3", idx); end
    fs_req = 4'b1001;
    run_xfer(1, idx, bt, fd_seen, fsc, ok);
    checks++; if (!ok || idx != 0 || bt !== 4'hE) begin errors++; $display("FAIL wrap_second got %0d/%h want 0/e", idx, bt); end
    run_xfer(0, idx, bt, fd_seen, fsc, ok);
    checks++; if (!ok || idx != 3 || bt !== 4'hA) begin errors++; $display("FAIL wrap_third got %0d/%h want 3/a", idx, bt); end
  endtask

  task automatic test_mid_drop();
    do_reset();
    fd_com_send = 1'b1;
    tick(); tick();
    fd_com_send = 1'b0;
    checks++; if (fs_com_send !== 1'b0 || fd_req !== 4'b0000) begin errors++; $display("FAIL spurious_fd got fs=%b fd_req=%b want 0/0000", fs_com_send, fd_req); end
    req_btype = 16'h0090;
    fs_req = 4'b0010;
    tick();
    checks++; if (fs_com_send !== 1'b1 || send_idx !== 2'd1) begin errors++; $display("FAIL drop_grant got fs=%b idx=%0d want 1/1", fs_com_send, send_idx); end
    fs_req = 4'b0000;
    tick(); tick(); tick();
    checks++; if (fs_com_send !== 1'b1) begin errors++; $display("FAIL drop_send_held got %b want 1", fs_com_send); end
    fd_com_send = 1'b1;
    tick();
    fd_com_send = 1'b0;
    checks++; if (fd_req !== 4'b0010 || fs_com_send !== 1'b0) begin errors++; $display("FAIL drop_done got fd_req=%b fs=%b want 0010/0", fd_req, fs_com_send); end
    tick();
    checks++; if (fd_req !== 4'b0000 || fs_com_send !== 1'b0) begin errors++; $display("FAIL drop_idle got fd_req=%b fs=%b want 0000/0", fd_req, fs_com_send); end
  endtask

  task automatic test_reset_mid_send();
    int idx; logic [3:0] bt; logic [NUM_REQ-1:0] fd_seen; logic fsc; bit ok;
    do_reset();
    req_btype = 16'h0C04;
    fs_req = 4'b0001;
    run_xfer(0, idx, bt, fd_seen, fsc, ok);
    fs_req = 4'b0100;
    tick(); tick();
    checks++; if (fs_com_send !== 1'b1 || send_idx !== 2'd2) begin errors++; $display("FAIL rstmid_grant got fs=%b idx=%0d want 1/2", fs_com_send, send_idx); end
    rst = 1'b1;
    #1;
    checks++; if (fs_com_send !== 1'b0 || fd_req !== 4'b0000) begin errors++; $display("FAIL rstmid_async got fs=%b fd_req=%b want 0/0000", fs_com_send, fd_req); end
    checks++; if (send_idx !== 2'd0 || send_btype !== 4'h0) begin errors++; $display("FAIL rstmid_regs got idx=%0d bt=%h want 0/0", send_idx, send_btype); end
    fs_req = 4'b0101;
    tick(); tick();
    rst = 1'b0;
    tick();
    checks++; if (fs_com_send !== 1'b1 || send_idx !== 2'd0) begin errors++; $display("FAIL rstmid_ptr0 got fs=%b idx=%0d want 1/0", fs_com_send, send_idx); end
    run_xfer(0, idx, bt, fd_seen, fsc, ok);
    run_xfer(0, idx, bt, fd_seen, fsc, ok);
    checks++; if (!ok || idx != 2 || bt !== 4'hC) begin errors++; $display("FAIL rstmid_regrant got %0d/%h want 2/c", idx, bt); end
  endtask

  task automatic test_timeout();
    int n;
    do_reset();
    req_btype = 16'h0050;
    fs_req = 4'b0010;
    n = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (fs_com_send === 1'b1) n++;
      else if (n > 0) break;
    end
`ifdef COM_ARB_TIMEOUT_EN
    checks++; if (n != TIMEOUT) begin errors++; $display("FAIL timeout_send_cycles got %0d want %0d", n, TIMEOUT); end
    checks++; if (fd_req !== 4'b0010 || err_timeout !== 1'b1) begin errors++; $display("FAIL timeout_done got fd_req=%b err=%b want 0010/1", fd_req, err_timeout); end
    fs_req = 4'b0000;
    repeat (5) tick();
    checks++; if (err_timeout !== 1'b1 || fs_com_send !== 1'b0) begin errors++; $display("FAIL timeout_sticky got err=%b fs=%b want 1/0", err_timeout, fs_com_send); end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    checks++; if (err_timeout !== 1'b0) begin errors++; $display("FAIL timeout_clear got %b want 0", err_timeout); end
    err_clr = 1'b1;
    fs_req = 4'b0010;
    n = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (fs_com_send === 1'b1) n++;
      else if (n > 0) break;
    end
    checks++; if (err_timeout !== 1'b1 || fd_req !== 4'b0010) begin errors++; $display("FAIL timeout_set_wins got err=%b fd_req=%b want 1/0010", err_timeout, fd_req); end
    err_clr = 1'b0;
    fs_req = 4'b0000;
    tick();
`else
    checks++; if (n != 40 || fs_com_send !== 1'b1) begin errors++; $display("FAIL no_timeout_send got %0d cycles fs=%b want 40/1", n, fs_com_send); end
    checks++; if (err_timeout !== 1'b0) begin errors++; $display("FAIL no_timeout_err got %b want 0", err_timeout); end
    fd_com_send = 1'b1;
    tick();
    fd_com_send = 1'b0;
    checks++; if (fd_req !== 4'b0010) begin errors++; $display("FAIL no_timeout_done got %b want 0010", fd_req); end
    fs_req = 4'b0000;
    tick();
`endif
  endtask

  // Randomized traffic against a model: winner = first pending source from ptr with wrap.
  task automatic test_random();
    int idx; logic [3:0] bt; logic [NUM_REQ-1:0] fd_seen; logic fsc; bit ok;
    int exp_idx; logic [3:0] exp_bt; int waits[NUM_REQ];
    logic [NUM_REQ-1:0] new_bits;
    do_reset();
    for (int i = 0; i < NUM_REQ; i++) waits[i] = 0;
    fs_req = NUM_REQ'($urandom) | 4'b0001;
    req_btype = 16'($urandom);
    for (int t = 0; t < 60; t++) begin
      exp_idx = -1;
      for (int k = 0; k < NUM_REQ; k++) begin
        if (exp_idx < 0 && fs_req[(m_ptr + k) % NUM_REQ]) exp_idx = (m_ptr + k) % NUM_REQ;
      end
      exp_bt = 4'(req_btype >> (4 * exp_idx));
      run_xfer(int'($urandom_range(0, 3)), idx, bt, fd_seen, fsc, ok);
      checks++; if (!ok || idx != exp_idx || bt !== exp_bt) begin errors++; $display("FAIL rand_grant[%0d] got %0d/%h want %0d/%h", t, idx, bt, exp_idx, exp_bt); end
      checks++; if (fd_seen !== 4'(1 << exp_idx) || fsc !== 1'b0) begin errors++; $display("FAIL rand_fd[%0d] got %b fs=%b want %b", t, fd_seen, fsc, 4'(1 << exp_idx)); end
      checks++; if (waits[exp_idx] > NUM_REQ - 1) begin errors++; $display("FAIL rand_fair[%0d] src %0d waited %0d want <=%0d", t, exp_idx, waits[exp_idx], NUM_REQ - 1); end
      checks++; if (send_btype !== exp_bt || fs_com_send !== 1'b0) begin errors++; $display("FAIL rand_hold[%0d] got %h fs=%b want %h/0", t, send_btype, fs_com_send, exp_bt); end
      for (int i = 0; i < NUM_REQ; i++) if (fs_req[i]) waits[i]++;
      m_ptr = (exp_idx + 1) % NUM_REQ;
      new_bits = NUM_REQ'($urandom) & ~fs_req;
      for (int i = 0; i < NUM_REQ; i++) if (new_bits[i]) waits[i] = 0;
      fs_req = fs_req | new_bits;
      if (fs_req == '0) begin
        idx = int'($urandom_range(0, NUM_REQ - 1));
        fs_req[idx] = 1'b1;
        waits[idx] = 0;
      end
      req_btype = 16'($urandom);
    end
    fs_req = '0;
    repeat (3) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1, "time limit");
  end

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_wrap();
    test_mid_drop();
    test_reset_mid_send();
    test_timeout();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
